rs_issue_array: RTL
===================

Name: rs_issue_array

Overview:
- Parametrised successor to the per-FU reservation-station issuer.
- Holds RS_DEPTH entries per functional unit and captures operands from the common data bus, with CDB_PORTS parallel broadcast channels.
- Selects the oldest fully-ready entry per FU and dispatches it over a valid/ready handshake.
- Sits between rename/ROB allocation and the FU array; supports pipeline flush.

Parameters:
FU_COUNT, 8, number of functional units / RS banks
RS_DEPTH, 4, entries per bank
DATA_W, 8, operand/value width
TAG_W, 4, physical register tag width
ROB_W, 8, ROB id width
OP_W, 8, opcode/control word width
CDB_PORTS, 2, parallel CDB broadcast channels

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
issue_valid  in  1  instruction presented for issue
issue_fuid  in  $clog2(FU_COUNT)  target bank
issue_op  in  OP_W  opcode/control (flags, wb select)
issue_robid  in  ROB_W  ROB id
issue_src_tag  in  2 x TAG_W  source tags
issue_src_rdy  in  2  source value already available
issue_src_val  in  2 x DATA_W  source value if ready
stall  out  1  issue not accepted this cycle
cdb_valid  in  CDB_PORTS  broadcast valid per channel
cdb_tag  in  CDB_PORTS x TAG_W  broadcast tag
cdb_val  in  CDB_PORTS x DATA_W  broadcast value
flush  in  1  discard all entries
fu_valid  out  FU_COUNT  dispatch valid per FU
fu_ready  in  FU_COUNT  FU accepts dispatch
fu_op  out  FU_COUNT x OP_W  dispatched opcode
fu_robid  out  FU_COUNT x ROB_W  dispatched ROB id
fu_src_val  out  FU_COUNT x 2 x DATA_W  dispatched operands
bank_count  out  FU_COUNT x $clog2(RS_DEPTH+1)  occupied entries per bank

Behaviour:
- Reset/flush: all entries invalid, age state cleared, bank_count = 0. fu_valid is 0 and dispatch buses are 0 from the next edge. stall = 0 while rst is high.
- Flush outranks issue, wakeup and dispatch in the same cycle; the issuing instruction is dropped.
- stall is combinational: issue_valid && bank[issue_fuid] full.
  - Full means occupancy == RS_DEPTH before the current cycle's dispatch.
  - A dispatch in the same cycle does not relieve stall.
- Accept = issue_valid && !stall && !flush. The entry is written into the lowest-index free slot at the clock edge.
- Allocation CDB bypass: a source with issue_src_rdy = 0 whose tag matches a valid CDB channel in the issue cycle is written as ready, with that value.
- Wakeup: every valid, unready source compares against all CDB channels each cycle. On a match, the value is captured and the source is marked ready at the edge.
  - If multiple channels carry the same tag, the lowest channel index wins.
  - A tag compare applies only while its source is unready; later broadcasts never overwrite a captured value.
- Eligibility: entry valid and both sources ready (registered state only). Latency is 1 cycle from allocate-with-ready or wakeup to fu_valid.
- Select: per bank, the oldest eligible entry, by allocation order, maintained with an age matrix or equivalent.
  - fu_valid[i] = an eligible entry exists in bank i.
  - The fu_* buses show that entry combinationally from state, and are 0 when fu_valid is 0.
- Dispatch: fu_valid && fu_ready frees the entry at the edge.
  - Without fu_ready the same entry stays selected and its outputs stay stable, unless an older entry becomes eligible; younger entries never preempt it.
- Same-bank allocate and dispatch in one cycle: both take effect, and bank_count stays the same.
- Simultaneous issue to bank A with dispatch from bank B: independent.
- bank_count updates at the edge: +1 on accept, −1 on dispatch. It never exceeds RS_DEPTH and never goes below 0.
- A CDB tag matching no entry is ignored.

Test Plan:
- Reset, then issue to FU 2 with both issue_src_rdy = 1, values 0x11 and 0x22, robid 5 -> next cycle fu_valid[2] = 1, fu_src_val = {0x22, 0x11}, fu_robid = 5; with fu_ready = 1, bank_count[2] returns to 0.
- Issue to FU 0 with src0 tag 3 unready; two cycles later cdb_valid[1] = 1, tag 3, val 0x7A -> fu_valid[0] rises the cycle after the broadcast with src0 = 0x7A. Also drive tag 3 on both channels in the same cycle -> channel 0's value is captured.
- Hold fu_ready[1] = 0 and issue 4 ready ops (robid 1–4) to FU 1 -> 5th issue asserts stall and is dropped. Then release fu_ready -> dispatch order is robid 1, 2, 3, 4.
- Issue robid 1 unready, then robid 2 ready, to FU 3 -> robid 2 dispatches first. Wake robid 1 -> it dispatches next.
- Issue with an unready tag matching the same-cycle cdb_tag 9, val 0x5C -> the entry is eligible the next cycle holding 0x5C.
- Fill FU 4 with 3 entries, then assert flush together with issue_valid -> the cycle after, all fu_valid = 0, bank_count = 0, and the issued instruction is absent.

Source files
------------

// File: rtl/rs_issue_array.sv
`default_nettype none
// ============================================================================
//  Module   : rs_issue_array
//  Purpose  : Banked reservation stations, one bank of RS_DEPTH entries per
//             functional unit. Entries capture operands from a multi-channel
//             common data bus. Each bank dispatches its oldest fully-ready
//             entry to its FU over a valid/ready handshake.
//  Revision : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst         clock, synchronous active-high reset
//    issue_*          instruction presented for allocation into bank issue_fuid
//    stall            issue_valid while the target bank is full
//    cdb_*            CDB_PORTS parallel result broadcasts (tag + value)
//    flush            discards every entry and any issue in the same cycle
//    fu_valid/ready   per-FU dispatch handshake
//    fu_op/robid/src_val  payload of the selected entry (zero when not valid)
//    bank_count       occupied entries per bank
// ============================================================================
module rs_issue_array #(
    parameter int FU_COUNT  = 8,
    parameter int RS_DEPTH  = 4,
    parameter int DATA_W    = 8,
    parameter int TAG_W     = 4,
    parameter int ROB_W     = 8,
    parameter int OP_W      = 8,
    parameter int CDB_PORTS = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       issue_valid,
    input  logic [$clog2(FU_COUNT)-1:0]                issue_fuid,
    input  logic [OP_W-1:0]                            issue_op,
    input  logic [ROB_W-1:0]                           issue_robid,
    input  logic [2*TAG_W-1:0]                         issue_src_tag,
    input  logic [1:0]                                 issue_src_rdy,
    input  logic [2*DATA_W-1:0]                        issue_src_val,
    output logic                                       stall,
    input  logic [CDB_PORTS-1:0]                       cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0]                 cdb_tag,
    input  logic [CDB_PORTS*DATA_W-1:0]                cdb_val,
    input  logic                                       flush,
    output logic [FU_COUNT-1:0]                        fu_valid,
    input  logic [FU_COUNT-1:0]                        fu_ready,
    output logic [FU_COUNT*OP_W-1:0]                   fu_op,
    output logic [FU_COUNT*ROB_W-1:0]                  fu_robid,
    output logic [FU_COUNT*2*DATA_W-1:0]               fu_src_val,
    output logic [FU_COUNT*$clog2(RS_DEPTH+1)-1:0]     bank_count
);

    localparam int C_FU_W  = $clog2(FU_COUNT);
    localparam int C_IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int C_CNT_W = $clog2(RS_DEPTH + 1);

    // Returns {hit, value}; the lowest-numbered matching channel wins.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]            tag,
        input logic [CDB_PORTS-1:0]        vld,
        input logic [CDB_PORTS*TAG_W-1:0]  tags,
        input logic [CDB_PORTS*DATA_W-1:0] vals
    );
        logic [DATA_W:0] result;
        result = '0;
        for (int c = CDB_PORTS - 1; c >= 0; c--) begin
            if (vld[c] && (tags[c*TAG_W +: TAG_W] == tag)) begin
                result = {1'b1, vals[c*DATA_W +: DATA_W]};
            end
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    logic                r_valid [FU_COUNT][RS_DEPTH];
    logic [OP_W-1:0]     r_op    [FU_COUNT][RS_DEPTH];
    logic [ROB_W-1:0]    r_robid [FU_COUNT][RS_DEPTH];
    logic [TAG_W-1:0]    r_tag   [FU_COUNT][RS_DEPTH][2];
    logic                r_rdy   [FU_COUNT][RS_DEPTH][2];
    logic [DATA_W-1:0]   r_val   [FU_COUNT][RS_DEPTH][2];
    // r_older[f][i][j] = 1 when entry i of bank f was allocated before entry j.
    // Only meaningful between two valid entries.
    logic                r_older [FU_COUNT][RS_DEPTH][RS_DEPTH];
    logic [C_CNT_W-1:0]  r_count [FU_COUNT];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [DATA_W:0]     w_wake     [FU_COUNT][RS_DEPTH][2];
    logic                w_iss_rdy  [2];
    logic [DATA_W-1:0]   w_iss_val  [2];
    logic                w_elig     [FU_COUNT][RS_DEPTH];
    logic                w_oldest;
    logic                w_sel_vld  [FU_COUNT];
    logic [C_IDX_W-1:0]  w_sel_idx  [FU_COUNT];
    logic [C_IDX_W-1:0]  w_free_idx [FU_COUNT];
    logic                w_alloc    [FU_COUNT];
    logic                w_disp     [FU_COUNT];
    logic                w_accept;
    logic [DATA_W:0]     w_iss_hit;

    // Full is judged on registered occupancy, so a same-cycle dispatch
    // never releases the stall.
    assign stall    = !rst && issue_valid &&
                      (r_count[issue_fuid] == C_CNT_W'(RS_DEPTH));
    assign w_accept = issue_valid && !stall && !flush && !rst;

    // Source readiness for the instruction being allocated, including a
    // bypass from a same-cycle broadcast.
    always_comb begin
        w_iss_hit = '0;
        for (int s = 0; s < 2; s++) begin
            w_iss_hit    = cdb_lookup(issue_src_tag[s*TAG_W +: TAG_W],
                                      cdb_valid, cdb_tag, cdb_val);
            w_iss_rdy[s] = issue_src_rdy[s] | w_iss_hit[DATA_W];
            w_iss_val[s] = issue_src_rdy[s] ? issue_src_val[s*DATA_W +: DATA_W]
                                            : w_iss_hit[DATA_W-1:0];
        end
    end

    always_comb begin
        for (int f = 0; f < FU_COUNT; f++) begin
            for (int e = 0; e < RS_DEPTH; e++) begin
                for (int s = 0; s < 2; s++) begin
                    w_wake[f][e][s] = cdb_lookup(r_tag[f][e][s],
                                                 cdb_valid, cdb_tag, cdb_val);
                end
            end
        end
    end

    // Per-bank oldest-ready select and lowest free slot.
    always_comb begin
        w_oldest = 1'b0;
        for (int f = 0; f < FU_COUNT; f++) begin
            w_sel_vld[f]  = 1'b0;
            w_sel_idx[f]  = '0;
            w_free_idx[f] = '0;
            for (int e = 0; e < RS_DEPTH; e++) begin
                w_elig[f][e] = r_valid[f][e] && r_rdy[f][e][0] && r_rdy[f][e][1];
            end
            for (int e = RS_DEPTH - 1; e >= 0; e--) begin
                if (!r_valid[f][e]) begin
                    w_free_idx[f] = C_IDX_W'(e);
                end
            end
            for (int e = 0; e < RS_DEPTH; e++) begin
                w_oldest = w_elig[f][e];
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if ((j != e) && w_elig[f][j] && r_older[f][j][e]) begin
                        w_oldest = 1'b0;
                    end
                end
                if (w_oldest) begin
                    w_sel_vld[f] = 1'b1;
                    w_sel_idx[f] = C_IDX_W'(e);
                end
            end
            w_alloc[f] = w_accept && (issue_fuid == C_FU_W'(f));
            w_disp[f]  = w_sel_vld[f] && fu_ready[f];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        fu_valid   = '0;
        fu_op      = '0;
        fu_robid   = '0;
        fu_src_val = '0;
        bank_count = '0;
        for (int f = 0; f < FU_COUNT; f++) begin
            fu_valid[f] = w_sel_vld[f];
            bank_count[f*C_CNT_W +: C_CNT_W] = r_count[f];
            if (w_sel_vld[f]) begin
                fu_op[f*OP_W +: OP_W]                  = r_op[f][w_sel_idx[f]];
                fu_robid[f*ROB_W +: ROB_W]             = r_robid[f][w_sel_idx[f]];
                fu_src_val[(2*f)*DATA_W +: DATA_W]     = r_val[f][w_sel_idx[f]][0];
                fu_src_val[(2*f+1)*DATA_W +: DATA_W]   = r_val[f][w_sel_idx[f]][1];
            end
        end
    end

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int f = 0; f < FU_COUNT; f++) begin
                r_count[f] <= '0;
                for (int e = 0; e < RS_DEPTH; e++) begin
                    r_valid[f][e] <= 1'b0;
                    for (int j = 0; j < RS_DEPTH; j++) begin
                        r_older[f][e][j] <= 1'b0;
                    end
                end
            end
        end else begin
            for (int f = 0; f < FU_COUNT; f++) begin
                if (w_alloc[f] && !w_disp[f]) begin
                    r_count[f] <= r_count[f] + C_CNT_W'(1);
                end else if (!w_alloc[f] && w_disp[f]) begin
                    r_count[f] <= r_count[f] - C_CNT_W'(1);
                end

                for (int e = 0; e < RS_DEPTH; e++) begin
                    // Capture applies only to unready sources, so a value
                    // once held is never overwritten by later broadcasts.
                    for (int s = 0; s < 2; s++) begin
                        if (r_valid[f][e] && !r_rdy[f][e][s] && w_wake[f][e][s][DATA_W]) begin
                            r_rdy[f][e][s] <= 1'b1;
                            r_val[f][e][s] <= w_wake[f][e][s][DATA_W-1:0];
                        end
                    end

                    if (w_disp[f] && (w_sel_idx[f] == C_IDX_W'(e))) begin
                        r_valid[f][e] <= 1'b0;
                    end

                    // The allocation slot is free in the current state, so it
                    // never collides with the dispatch or wakeup of that slot.
                    if (w_alloc[f] && (w_free_idx[f] == C_IDX_W'(e))) begin
                        r_valid[f][e] <= 1'b1;
                        r_op[f][e]    <= issue_op;
                        r_robid[f][e] <= issue_robid;
                        for (int s = 0; s < 2; s++) begin
                            r_tag[f][e][s] <= issue_src_tag[s*TAG_W +: TAG_W];
                            r_rdy[f][e][s] <= w_iss_rdy[s];
                            r_val[f][e][s] <= w_iss_val[s];
                        end
                    end

                    // New entry is younger than everything already present.
                    for (int j = 0; j < RS_DEPTH; j++) begin
                        if (w_alloc[f] && (w_free_idx[f] == C_IDX_W'(e))) begin
                            r_older[f][e][j] <= 1'b0;
                        end else if (w_alloc[f] && (w_free_idx[f] == C_IDX_W'(j))) begin
                            r_older[f][e][j] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
